// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        WAIT,
        CLEAR,
        WB
    } state_e;

    // Op select is {mem_read, mem_write}
    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b10;
    localparam logic [1:0] OP_STORE   = 2'b01;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

endpackage

// File: rtl/mem_access_ctrl_done_sync.sv
// Two-flop synchronizer for the responder's completion level.
module done_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: issues one data-memory request per execute result
// and returns a single write-back beat under a valid/ready handshake.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned REG_ADDR_W     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  exec_valid,
    output logic                  exec_ready,
    input  logic [WIDTH-1:0]      exec_result,
    input  logic [WIDTH-1:0]      exec_rd2,
    input  logic                  exec_mem_read,
    input  logic                  exec_mem_write,
    input  logic [REG_ADDR_W-1:0] exec_dest,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [WIDTH-1:0]      result,
    output logic [WIDTH-1:0]      rd2,
    output logic                  executeComplete,
    output logic                  resetDataMemory,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  memoryOperationComplete,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WIDTH-1:0]      wb_data,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  wb_write_en,
    output logic                  wb_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [1:0]            op_q, op_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [WIDTH-1:0]      rd2_q, rd2_d;
    logic                  ec_q, ec_d;
    logic                  rdm_q, rdm_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  expired_q, expired_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0]      wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic                  wb_we_q, wb_we_d;
    logic                  wb_err_q, wb_err_d;
    logic                  done_s;
    logic [1:0]            exec_op;

    assign exec_op = {exec_mem_read, exec_mem_write};

    done_sync u_done_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (memoryOperationComplete),
        .q       (done_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            ready_q    <= 1'b0;
            op_q       <= OP_NONE;
            result_q   <= '0;
            rd2_q      <= '0;
            ec_q       <= 1'b0;
            rdm_q      <= 1'b0;
            cnt_q      <= '0;
            expired_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
            wb_we_q    <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            op_q       <= op_d;
            result_q   <= result_d;
            rd2_q      <= rd2_d;
            ec_q       <= ec_d;
            rdm_q      <= rdm_d;
            cnt_q      <= cnt_d;
            expired_q  <= expired_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_dest_q  <= wb_dest_d;
            wb_we_q    <= wb_we_d;
            wb_err_q   <= wb_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        rd2_d     = rd2_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        wb_data_d = wb_data_q;
        wb_dest_d = wb_dest_q;
        wb_we_d   = wb_we_q;
        wb_err_d  = wb_err_q;

        unique case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (exec_valid) begin
                    result_d  = exec_result;
                    rd2_d     = exec_rd2;
                    wb_dest_d = exec_dest;
                    if (exec_op == OP_ILLEGAL) begin
                        op_d      = OP_NONE;
                        wb_data_d = '0;
                        wb_we_d   = 1'b0;
                        wb_err_d  = 1'b1;
                        state_d   = WB;
                    end else begin
                        op_d    = exec_op;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout that expires on the same edge
                if (done_s) begin
                    wb_data_d = (op_q == OP_LOAD) ? rdata : result_q;
                    wb_we_d   = (op_q != OP_STORE);
                    wb_err_d  = 1'b0;
                    state_d   = CLEAR;
                end else if (expired_q) begin
                    wb_data_d = '0;
                    wb_we_d   = 1'b0;
                    wb_err_d  = 1'b1;
                    state_d   = CLEAR;
                end else if (cnt_q == CNT_MAX) begin
                    expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLEAR: state_d = WB;
            WB: begin
                if (wb_ready) begin
                    wb_err_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT;
        endcase

        // Strobes follow the state being entered so they line up with it
        ready_d    = (state_d == IDLE);
        ec_d       = (state_d == WAIT);
        wb_valid_d = (state_d == WB);
        rdm_d      = (state_d == CLEAR) || (state_q == INIT);
    end

    assign exec_ready      = ready_q;
    assign memRead         = op_q[1];
    assign memWrite        = op_q[0];
    assign result          = result_q;
    assign rd2             = rd2_q;
    assign executeComplete = ec_q;
    assign resetDataMemory = rdm_q;
    assign wb_valid        = wb_valid_q;
    assign wb_data         = wb_data_q;
    assign wb_dest         = wb_dest_q;
    assign wb_write_en     = wb_we_q;
    assign wb_err          = wb_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural memory responder.
module tb_mem_access_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned TO = 8;

    typedef struct {
        logic [W-1:0]  data;
        logic [RW-1:0] dest;
        logic          we;
        logic          err;
        logic          chk_data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          exec_valid;
    logic          exec_ready;
    logic [W-1:0]  exec_result;
    logic [W-1:0]  exec_rd2;
    logic          exec_mem_read;
    logic          exec_mem_write;
    logic [RW-1:0] exec_dest;
    logic          memRead;
    logic          memWrite;
    logic [W-1:0]  result;
    logic [W-1:0]  rd2;
    logic          executeComplete;
    logic          resetDataMemory;
    logic [W-1:0]  rdata;
    logic          mem_done;
    logic          wb_valid;
    logic          wb_ready;
    logic [W-1:0]  wb_data;
    logic [RW-1:0] wb_dest;
    logic          wb_write_en;
    logic          wb_err;

    logic [W-1:0] mem [256];
    logic [W-1:0] ref_mem [256];
    logic         never_complete = 1'b0;
    logic         last_mem_read;
    int           ec_rises = 0;
    int           rdm_pulses = 0;
    int           checks = 0;
    int           failures = 0;
    exp_t         sb[$];

    mem_access_ctrl #(
        .WIDTH          (W),
        .REG_ADDR_W     (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .exec_valid              (exec_valid),
        .exec_ready              (exec_ready),
        .exec_result             (exec_result),
        .exec_rd2                (exec_rd2),
        .exec_mem_read           (exec_mem_read),
        .exec_mem_write          (exec_mem_write),
        .exec_dest               (exec_dest),
        .memRead                 (memRead),
        .memWrite                (memWrite),
        .result                  (result),
        .rd2                     (rd2),
        .executeComplete         (executeComplete),
        .resetDataMemory         (resetDataMemory),
        .rdata                   (rdata),
        .memoryOperationComplete (mem_done),
        .wb_valid                (wb_valid),
        .wb_ready                (wb_ready),
        .wb_data                 (wb_data),
        .wb_dest                 (wb_dest),
        .wb_write_en             (wb_write_en),
        .wb_err                  (wb_err)
    );

    always #5 clk = ~clk;

    always @(posedge executeComplete) ec_rises++;
    always @(posedge resetDataMemory) rdm_pulses++;

    function automatic logic [W-1:0] seed_val(int i);
        return W'(i * 37) ^ 16'hA5C3;
    endfunction

    // Responder: acts on the request strobe, completes off-edge, cleared by the pulse
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = seed_val(i);
        mem[3] = 16'h00A5;
        rdata = '0;
        mem_done = 1'b0;
        last_mem_read = 1'b0;
        forever begin
            @(posedge executeComplete or posedge resetDataMemory);
            if (resetDataMemory) begin
                mem_done = 1'b0;
            end else begin
                last_mem_read = memRead;
                if (!never_complete) begin
                    if (memWrite) mem[result[7:0]] = rd2;
                    if (memRead) rdata = mem[result[7:0]];
                    #2 mem_done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({exec_ready, memRead, memWrite, result, rd2, executeComplete,
                    resetDataMemory, wb_valid, wb_data, wb_dest, wb_write_en, wb_err});
    endfunction

    // Reference model: expected beat and latency window from the op rules
    task automatic model(input logic rd, input logic wr, input logic [W-1:0] res,
                         input logic [W-1:0] d2, input logic [RW-1:0] dest,
                         output exp_t e, output int lo, output int hi);
        e.dest = dest; e.err = 1'b0; e.we = 1'b1; e.data = res; e.chk_data = 1'b1;
        lo = 5; hi = 5;
        if (rd && wr) begin
            e.err = 1'b1; e.we = 1'b0; e.data = '0; lo = 0; hi = 0;
        end else if (never_complete) begin
            e.err = 1'b1; e.we = 1'b0; e.data = '0; lo = TO + 3; hi = TO + 3;
        end else if (wr) begin
            e.we = 1'b0; e.chk_data = 1'b0; ref_mem[res[7:0]] = d2; hi = 6;
        end else if (rd) begin
            e.data = ref_mem[res[7:0]];
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat actual=beat required=none");
                end else begin
                    e = sb.pop_front();
                    check("wb_dest", 64'(wb_dest), 64'(e.dest));
                    check("wb_write_en", 64'(wb_write_en), 64'(e.we));
                    check("wb_err", 64'(wb_err), 64'(e.err));
                    if (e.chk_data) check("wb_data", 64'(wb_data), 64'(e.data));
                end
            end
        end
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [W-1:0] res,
                          input logic [W-1:0] d2, input logic [RW-1:0] dest, input int delay);
        exp_t e;
        int lo, hi, lat, ec0, rdm0;
        bit ok;
        model(rd, wr, res, d2, dest, e, lo, hi);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exec_ready) begin ok = 1'b1; break; end
        end
        check("exec_ready_wait", 64'(ok), 64'(1));
        exec_valid = 1'b1; exec_result = res; exec_rd2 = d2;
        exec_mem_read = rd; exec_mem_write = wr; exec_dest = dest;
        ec0 = ec_rises; rdm0 = rdm_pulses;
        @(posedge clk);
        #1;
        sb.push_back(e);
        // Junk held on the execute side while busy must be ignored
        exec_result = ~res; exec_rd2 = ~d2; exec_dest = ~dest;
        exec_mem_read = ~rd; exec_mem_write = wr;
        if (delay == 0) wb_ready = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wb_valid) begin lat = k; break; end
        end
        exec_valid = 1'b0;
        check_range("wb_latency", lat, lo, hi);
        if (lat < 0) begin
            void'(sb.pop_back());
            wb_ready = 1'b0;
            return;
        end
        if (delay > 0) begin
            for (int j = 0; j < delay; j++) begin
                check("stall_valid", 64'(wb_valid), 64'(1));
                check("stall_dest", 64'(wb_dest), 64'(e.dest));
                check("stall_err", 64'(wb_err), 64'(e.err));
                if (e.chk_data) check("stall_data", 64'(wb_data), 64'(e.data));
                @(negedge clk);
            end
            @(posedge clk);
            #1 wb_ready = 1'b1;
        end
        @(posedge clk);
        #1 wb_ready = 1'b0;
        check("beat_ends", 64'(wb_valid), 64'(0));
        check("back_to_idle", 64'(exec_ready), 64'(1));
        check("ec_rises", 64'(ec_rises - ec0), (rd && wr) ? 64'(0) : 64'(1));
        check("rdm_pulses", 64'(rdm_pulses - rdm0), (rd && wr) ? 64'(0) : 64'(1));
        if (rd && !wr && !never_complete) check("mem_read_level", 64'(last_mem_read), 64'(1));
        if (wr && !rd && !never_complete) check("store_mem", 64'(mem[res[7:0]]), 64'(d2));
    endtask

    task automatic reset_in_wait();
        int r0;
        bit ok;
        @(negedge clk);
        exec_valid = 1'b1; exec_result = 16'd3; exec_rd2 = '0;
        exec_mem_read = 1'b1; exec_mem_write = 1'b0; exec_dest = 3'd1;
        @(posedge clk);
        #1 exec_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (executeComplete) begin ok = 1'b1; break; end
        end
        check("reach_wait", 64'(ok), 64'(1));
        #2 reset_n = 1'b0;
        #1 check("reset_in_wait_outs", all_outs(), 64'(0));
        r0 = rdm_pulses;
        @(negedge clk);
        check("reset_held_outs", all_outs(), 64'(0));
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("init_pulse", 64'(rdm_pulses - r0), 64'(1));
        check("ready_after_init", 64'(exec_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [1:0] op;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
        ref_mem[3] = 16'h00A5;
        reset_n = 1'b0; exec_valid = 1'b0; exec_result = '0; exec_rd2 = '0;
        exec_mem_read = 1'b0; exec_mem_write = 1'b0; exec_dest = '0; wb_ready = 1'b0;
        fork monitor(); join_none

        #12 check("reset_outs", all_outs(), 64'(0));
        r0 = rdm_pulses;
        #11 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("init_pulse", 64'(rdm_pulses - r0), 64'(1));
        check("ready_after_init", 64'(exec_ready), 64'(1));

        do_txn(1'b1, 1'b0, 16'd3, 16'h0, 3'd2, 0);
        do_txn(1'b0, 1'b1, 16'd5, 16'h1234, 3'd3, 1);
        do_txn(1'b0, 1'b0, 16'h0042, 16'h0, 3'd4, 4);
        do_txn(1'b1, 1'b1, 16'd7, 16'hBEEF, 3'd5, 0);
        never_complete = 1'b1;
        do_txn(1'b1, 1'b0, 16'd3, 16'h0, 3'd6, 2);
        never_complete = 1'b0;
        do_txn(1'b1, 1'b0, 16'd5, 16'h0, 3'd7, 0);
        reset_in_wait();
        do_txn(1'b1, 1'b0, 16'd3, 16'h0, 3'd1, 0);

        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            do_txn(op[1], op[0], W'($urandom_range(0, 15)), W'($urandom),
                   RW'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage initiator between the execute stage and the data memory. It accepts one execute-stage result at a time and drives the data memory's `memRead`/`memWrite`/`result`/`rd2` signals. It issues the `executeComplete` strobe, waits for `memoryOperationComplete`, captures `rdata`, and clears the completion with a `resetDataMemory` pulse. It then presents one write-back beat to the register-file stage under a valid/ready handshake.

## Interface
- `WIDTH`, 16, data and address width.
- `REG_ADDR_W`, 3, destination register index width.
- `TIMEOUT_CYCLES`, 16, maximum WAIT cycles before the request is abandoned; must be ≥ 4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `exec_valid` in 1: execute stage presents a result.
- `exec_ready` out 1: high only in IDLE.
- `exec_result` in WIDTH: ALU result, or memory address for load/store.
- `exec_rd2` in WIDTH: store data.
- `exec_mem_read` in 1, `exec_mem_write` in 1: operation select.
- `exec_dest` in REG_ADDR_W: destination register.
- `memRead` out 1, `memWrite` out 1, `result` out WIDTH, `rd2` out WIDTH: registered request toward data memory.
- `executeComplete` out 1: request strobe; the responder acts on its rising edge.
- `resetDataMemory` out 1: one-cycle pulse that clears the responder's completion flag.
- `rdata` in WIDTH: responder read data.
- `memoryOperationComplete` in 1: responder completion level.
- `wb_valid` out 1, `wb_ready` in 1: write-back handshake.
- `wb_data` out WIDTH, `wb_dest` out REG_ADDR_W, `wb_write_en` out 1, `wb_err` out 1: write-back beat.

## Operation
- States: INIT, IDLE, ISSUE, WAIT, CLEAR, WB.
- Reset (async assert): state goes to INIT. All registered outputs are 0, including `memRead`, `memWrite`, `result`, `rd2`, `executeComplete`, `resetDataMemory`, `wb_*` and the synchronizer flops. `exec_ready` is 0.
- INIT: `resetDataMemory`=1 for exactly one cycle, so a completion left over from before reset is cleared. Then IDLE.
- IDLE: `exec_ready`=1. When `exec_valid` is high at a rising edge, the block latches all `exec_*` fields into the request registers.
  - Legal op (read and write not both high): go to ISSUE.
  - Both `exec_mem_read` and `exec_mem_write` high: illegal. No request is issued; `wb_err`=1, `wb_write_en`=0, `wb_data`=0; go to WB.
- ISSUE: `executeComplete`=1, held through WAIT. The timeout counter clears. Next state is WAIT.
- WAIT: the counter increments each cycle. Transitions:
  - Synchronized completion high: capture `rdata` into `wb_data`, go to CLEAR.
  - Counter reaches TIMEOUT_CYCLES−1 first: `wb_data`=0, `wb_err`=1, go to CLEAR.
- CLEAR: `executeComplete`=0 and `resetDataMemory`=1 for one cycle. Then WB.
- WB: `wb_valid`=1, with all `wb_*` fields stable until `wb_ready` is sampled high. Then go to IDLE, with `wb_valid` and `wb_err` cleared.
- `wb_write_en` by operation:
  - Load or ALU-only, no error: 1.
  - Store or any error: 0.
- `wb_dest` = latched `exec_dest`.
- `memoryOperationComplete` passes through a 2-flop synchronizer, because the responder updates it off a non-clock edge. Only the second flop is used.
- Widths are pass-through; the block does no arithmetic except the counter, which is `$clog2(TIMEOUT_CYCLES)` bits and saturates in WAIT.

## Timing
- Acceptance edge = E0.
- `executeComplete` rises after E1.
- Load: responder completes before E2; sync output is high after E3; CLEAR runs in cycle E4–E5; `wb_valid` is high after E5.
- Store: responder completes at E2; `wb_valid` is high after E5 or E6, depending on whether the synchronizer catches E2.
- Timeout: `wb_valid` is high TIMEOUT_CYCLES+2 cycles after E1.
- At least 3 cycles separate CLEAR from the next WAIT, so the synchronizer has drained before completion is sampled again. No stale completion can be seen.
- `wb_ready` may already be high when WB is entered; the beat then lasts exactly one cycle.
- `exec_valid` outside IDLE is ignored, and the inputs are not latched.
- `reset_n` low in any state (including WAIT with `executeComplete` high) drops all outputs immediately. INIT runs after release.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum (INIT, IDLE, ISSUE, WAIT, CLEAR, WB);
  - op-select encoding constants (NONE=2'b00, LOAD=2'b10, STORE=2'b01, ILLEGAL=2'b11);
  - default WIDTH.
- Sub-module `done_sync`: 2-flop synchronizer with asynchronous active-low reset to 0.

## Test plan
- Load: addr 3, memory[3]=16'h00A5, dest 2 → `memRead`=1, `wb_data`=16'h00A5, `wb_dest`=2, `wb_write_en`=1, `wb_valid` at E5, `resetDataMemory` pulsed once.
- Store: addr 5, rd2=16'h1234 → memory[5]=16'h1234, `wb_write_en`=0, `wb_valid` at E5 or E6.
- ALU-only: result 16'h0042 → `wb_data`=16'h0042, `wb_write_en`=1; with `wb_ready` held low 4 cycles the beat stays stable, then a single accept.
- Illegal op: read=write=1 → no `executeComplete` edge, `wb_err`=1, `wb_write_en`=0, `wb_data`=0.
- Timeout: responder stubbed to never complete, TIMEOUT_CYCLES=8 → `wb_err`=1 and `wb_valid` 10 cycles after E1; the next load then succeeds normally.
- `reset_n` pulsed low in WAIT → all outputs 0 asynchronously; INIT emits one `resetDataMemory` pulse; a back-to-back load afterwards returns correct data.
